// File: rtl/capstone_pkg.sv
// Shared definitions for the bit-serial arithmetic slice: FSM encoding and
// the default datapath width.
package capstone_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder with its own carry flip-flop, used LSB-first across
// successive clock cycles.
module serial_fa_bit (
  input  logic CLK,
  input  logic RST_N,
  input  logic LD,
  input  logic LD_VAL,
  input  logic EN,
  input  logic A,
  input  logic B,
  output logic SUM,
  output logic CARRY
);

  assign SUM = A ^ B ^ CARRY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CARRY <= 1'b0;
    end else if (LD) begin
      CARRY <= LD_VAL;
    end else if (EN) begin
      CARRY <= (A & B) | (A & CARRY) | (B & CARRY);
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer driving an external shift-register
// accumulator: loads A, then feeds back sum bits for WIDTH cycles.
module serial_add_sequencer
  import capstone_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ACC_SOUT,
  output logic             ACC_LE,
  output logic [WIDTH-1:0] ACC_LOAD,
  output logic             ACC_SI,
  output logic             ACC_POUTE,
  output logic             BUSY,
  output logic             DONE,
  output logic             COUT,
  output logic [WIDTH-1:0] RESULT
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             carry;
  logic             fa_sum;
  logic             take;
  logic             in_shift;

  assign take     = (state == ST_IDLE) && START;
  assign in_shift = (state == ST_SHIFT);

  // Subtraction is A + ~B + 1: the +1 comes from presetting the carry.
  serial_fa_bit u_fa (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .LD     (take),
    .LD_VAL (SUB),
    .EN     (in_shift),
    .A      (ACC_SOUT),
    .B      (b_reg[0]),
    .SUM    (fa_sum),
    .CARRY  (carry)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_sh   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_LOAD;
            a_reg <= A;
            b_reg <= SUB ? ~B : B;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          b_reg  <= {1'b0, b_reg[WIDTH-1:1]};
          res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_q <= res_sh;
          cout_q   <= carry;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ACC_LE    = 1'b1;
    ACC_LOAD  = result_q;
    ACC_SI    = 1'b0;
    ACC_POUTE = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    RESULT    = result_q;
    COUT      = cout_q;
    case (state)
      ST_IDLE: begin
        // The accumulator has no hold mode, so it is refreshed every cycle.
        ACC_LOAD = result_q;
      end
      ST_LOAD: begin
        ACC_LOAD = a_reg;
        BUSY     = 1'b1;
      end
      ST_SHIFT: begin
        ACC_LE   = 1'b0;
        ACC_LOAD = res_sh;
        ACC_SI   = fa_sum;
        BUSY     = 1'b1;
      end
      ST_DONE: begin
        ACC_LOAD  = res_sh;
        ACC_POUTE = 1'b1;
        DONE      = 1'b1;
        RESULT    = res_sh;
        COUT      = carry;
      end
      default: begin
        ACC_LE = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a behavioural shift-register
// accumulator closing the serial loop.
module tb_serial_add_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_sout;
  logic       acc_le;
  logic [7:0] acc_load;
  logic       acc_si;
  logic       acc_poute;
  logic       busy;
  logic       done;
  logic       cout;
  logic [7:0] result;
  logic [7:0] acc;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[4];

  serial_add_sequencer #(.WIDTH(8)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .START     (start),
    .SUB       (sub),
    .A         (a),
    .B         (b),
    .ACC_SOUT  (acc_sout),
    .ACC_LE    (acc_le),
    .ACC_LOAD  (acc_load),
    .ACC_SI    (acc_si),
    .ACC_POUTE (acc_poute),
    .BUSY      (busy),
    .DONE      (done),
    .COUT      (cout),
    .RESULT    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator: parallel load, otherwise shift right with SI into the MSB.
  initial acc = 8'h00;
  always @(posedge clk) begin
    if (acc_le) acc <= acc_load;
    else        acc <= {acc_si, acc[7:1]};
  end
  assign acc_sout = acc[0];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic ec, input string nm);
    logic [7:0]  si;
    int unsigned nsi;
    int          dc;
    si  = '0;
    nsi = 0;
    dc  = -1;
    @(negedge clk);
    start = 1'b1; sub = s; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20 && dc < 0; c++) begin
      if (c > 1) @(negedge clk);
      if (!acc_le && nsi < 8) begin
        si[nsi] = acc_si;
        nsi++;
      end
      if (done) begin
        dc = c;
        chk({nm, " result@done"}, result, er);
        chk({nm, " cout@done"}, cout, ec);
        chk({nm, " poute@done"}, acc_poute, 1);
        chk({nm, " acc@done"}, acc, er);
      end
    end
    chk({nm, " done cycle"}, dc, 10);
    chk({nm, " si count"}, nsi, 8);
    chk({nm, " si bits"}, si, er);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk({nm, " hold result"}, result, er);
      chk({nm, " hold cout"}, cout, ec);
      chk({nm, " hold acc"}, acc, er);
      chk({nm, " hold done"}, done, 0);
    end
  endtask

  initial begin
    logic        exp_busy;
    logic        exp_done;
    logic        seen_done;
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;

    vecs[0] = '{sub: 1'b0, a: 8'h5A, b: 8'h33, exp_res: 8'h8D, exp_cout: 1'b0};
    vecs[1] = '{sub: 1'b0, a: 8'hFF, b: 8'h01, exp_res: 8'h00, exp_cout: 1'b1};
    vecs[2] = '{sub: 1'b1, a: 8'h10, b: 8'h01, exp_res: 8'h0F, exp_cout: 1'b1};
    vecs[3] = '{sub: 1'b1, a: 8'h01, b: 8'h02, exp_res: 8'hFF, exp_cout: 1'b0};

    repeat (2) @(negedge clk);
    chk("rst result", result, 0);
    chk("rst cout", cout, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst acc_le", acc_le, 1);
    chk("rst acc_load", acc_load, 0);
    chk("rst acc_si", acc_si, 0);
    chk("rst acc_poute", acc_poute, 0);

    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle acc_le", acc_le, 1);
      chk("idle acc_load", acc_load, 0);
      chk("idle done", done, 0);
    end

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_cout,
             $sformatf("vec%0d", i));
    end

    // START held high: operations begin at edges 0, 11 and 22.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp_busy = ((c >= 1 && c <= 9) || (c >= 12 && c <= 20) || (c >= 23 && c <= 31));
      exp_done = (c == 10 || c == 21 || c == 32);
      chk($sformatf("b2b busy c%0d", c), busy, exp_busy);
      chk($sformatf("b2b done c%0d", c), done, exp_done);
      if (c == 10) begin
        chk("b2b op0 result", result, 8'h46);
        chk("b2b op0 cout", cout, 0);
      end
      if (c == 21) begin
        chk("b2b op1 result", result, 8'h30);
        chk("b2b op1 cout", cout, 1);
      end
      if (c == 32) begin
        chk("b2b op2 result", result, 8'h65);
        chk("b2b op2 cout", cout, 1);
      end
      if (c == 3)  begin sub = 1'b1; a = 8'h50; b = 8'h20; end
      if (c == 14) begin sub = 1'b0; a = 8'hAA; b = 8'hBB; end
      if (c == 30) start = 1'b0;
    end

    // Reset asserted during the fourth SHIFT cycle.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h5A; b = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst acc_load", acc_load, 0);
    chk("midrst acc_le", acc_le, 1);
    chk("midrst result", result, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (k == 0) chk("midrst acc reload", acc, 0);
    end
    chk("midrst no done", seen_done, 0);
    run_op(1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
